// File: rtl/fifo_deq_serializer.sv
// Drains WIDTH-bit elements from a guarded upstream FIFO (first/deq) and
// re-emits each one as BEATS narrow words through a guarded enq, LSB beat first.
module fifo_deq_serializer #(
  parameter  int WIDTH = 704,
  parameter  int BEAT  = 32,
  localparam int BEATS = WIDTH / BEAT,
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] in_first,
  input  logic             in_first__RDY,
  input  logic             in_deq__RDY,
  output logic             in_deq__ENA,
  output logic [BEAT-1:0]  out_enq_v,
  output logic             out_enq_last,
  input  logic             out_enq__RDY,
  output logic             out_enq__ENA,
  output logic             busy
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;

  logic             last_s;
  logic             enq_ena_s;
  logic             load_s;

  // Handshake decode: a new element may be taken when idle or when the final
  // beat of the current one leaves in this very cycle (no bubble between elements).
  always_comb begin
    last_s    = busy_q && (idx_q == IDX_W'(BEATS - 1));
    enq_ena_s = busy_q && out_enq__RDY;
    load_s    = in_first__RDY && in_deq__RDY && (!busy_q || (enq_ena_s && last_s));
  end

  // Next-state: load wins over the last-beat retire, otherwise shift on each accepted beat.
  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    if (load_s) begin
      data_d = in_first;
      idx_d  = {IDX_W{1'b0}};
      busy_d = 1'b1;
    end else if (enq_ena_s) begin
      if (last_s) begin
        idx_d  = {IDX_W{1'b0}};
        busy_d = 1'b0;
      end else begin
        data_d = data_q >> BEAT;
        idx_d  = idx_q + IDX_W'(1);
      end
    end else begin
      data_d = data_q;
    end
  end

  // State registers with synchronous reset; a partially sent element is dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q <= {WIDTH{1'b0}};
      idx_q  <= {IDX_W{1'b0}};
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
    end
  end

  assign in_deq__ENA  = load_s;
  assign out_enq__ENA = enq_ena_s;
  assign out_enq_last = last_s;
  assign out_enq_v    = data_q[BEAT-1:0];
  assign busy         = busy_q;

endmodule

// File: tb/tb_fifo_deq_serializer.sv
// Scoreboard bench for fifo_deq_serializer: an upstream model queues expected
// beats at each dequeue, a monitor pops and compares on every accepted beat.
module tb_fifo_deq_serializer;
  localparam int W = 704;
  localparam int B = 32;
  localparam int N = W / B;

  logic          CLK = 1'b0;
  logic          RST;
  logic [W-1:0]  in_first;
  logic          in_first__RDY;
  logic          in_deq__RDY;
  logic          in_deq__ENA;
  logic [B-1:0]  out_enq_v;
  logic          out_enq_last;
  logic          out_enq__RDY;
  logic          out_enq__ENA;
  logic          busy;

  fifo_deq_serializer #(.WIDTH(W), .BEAT(B)) dut (
    .CLK(CLK), .RST(RST),
    .in_first(in_first), .in_first__RDY(in_first__RDY),
    .in_deq__RDY(in_deq__RDY), .in_deq__ENA(in_deq__ENA),
    .out_enq_v(out_enq_v), .out_enq_last(out_enq_last),
    .out_enq__RDY(out_enq__RDY), .out_enq__ENA(out_enq__ENA),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;
  logic [32:0] exp_q[$];
  logic [31:0] up_base[$];
  int beats = 0;
  int deq_cnt = 0;
  int cyc = 0;
  int first_cyc = -1;
  int last_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [W-1:0] mk(input logic [31:0] base);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*B +: B] = base + 32'(k);
    return r;
  endfunction

  // Monitor: compare every accepted beat against the scoreboard head
  always @(negedge CLK) begin
    logic [32:0] e;
    cyc++;
    if (!RST) begin
      if (out_enq__ENA) begin
        chk("enq_ena_without_rdy", {63'd0, out_enq__RDY}, 64'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", {32'd0, out_enq_v}, {32'd0, e[31:0]});
          chk("beat_last", {63'd0, out_enq_last}, {63'd0, e[32]});
          beats++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
        end
      end else if (busy && exp_q.size() > 0) begin
        chk("stall_hold", {32'd0, out_enq_v}, {32'd0, exp_q[0][31:0]});
      end
    end
  end

  // Upstream FIFO model: records dequeues, queues expected beats, presents next element
  initial begin
    logic deq;
    in_first = '0;
    in_first__RDY = 1'b0;
    forever begin
      @(negedge CLK);
      deq = in_deq__ENA && !RST;
      if (deq) begin
        chk("deq_guard", {62'd0, in_first__RDY, in_deq__RDY}, 64'd3);
        if (busy) chk("deq_only_on_last_beat", {63'd0, out_enq_last && out_enq__ENA}, 64'd1);
        if (up_base.size() > 0)
          for (int k = 0; k < N; k++) exp_q.push_back({(k == N-1) ? 1'b1 : 1'b0, up_base[0] + 32'(k)});
        deq_cnt++;
      end
      @(posedge CLK);
      #2;
      if (deq && up_base.size() > 0) void'(up_base.pop_front());
      in_first__RDY = (up_base.size() > 0);
      in_first = (up_base.size() > 0) ? mk(up_base[0]) : '0;
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || up_base.size() != 0) && n < budget) begin
      @(posedge CLK); #3; n++;
    end
    if (n >= budget) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n;
    n = 0;
    while (beats < target && n < budget) begin
      @(posedge CLK); #1; n++;
    end
    if (n >= budget) chk("beat_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    out_enq__RDY = 1'b0;
    in_deq__RDY = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_deq_ena", {63'd0, in_deq__ENA}, 64'd0);
    chk("rst_enq_ena", {63'd0, out_enq__ENA}, 64'd0);
    chk("rst_last", {63'd0, out_enq_last}, 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Single element, downstream always ready
    out_enq__RDY = 1'b1; beats = 0; deq_cnt = 0;
    up_base.push_back(32'hA000_0000);
    wait_drain(200);
    @(negedge CLK);
    chk("single_busy_drop", {63'd0, busy}, 64'd0);
    chk("single_beats", 64'(beats), 64'd22);
    chk("single_deq_cnt", 64'(deq_cnt), 64'd1);

    // Back-to-back: three elements, no gaps
    @(posedge CLK); #1;
    beats = 0; deq_cnt = 0; first_cyc = -1;
    up_base.push_back(32'hC000_0000);
    up_base.push_back(32'hC100_0000);
    up_base.push_back(32'hC200_0000);
    wait_drain(300);
    chk("b2b_beats", 64'(beats), 64'd66);
    chk("b2b_span", 64'(last_cyc - first_cyc + 1), 64'd66);
    chk("b2b_deq_cnt", 64'(deq_cnt), 64'd3);

    // Backpressure pattern 1,0,0,1,0,0,...
    @(posedge CLK); #1;
    beats = 0;
    up_base.push_back(32'hD000_0000);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || up_base.size() != 0 || i < 2); i++) begin
      out_enq__RDY = (i % 3 == 0);
      @(posedge CLK); #1;
    end
    out_enq__RDY = 1'b1;
    wait_drain(50);
    chk("bp_beats", 64'(beats), 64'd22);

    // Upstream valid but deq not ready
    @(posedge CLK); #1;
    beats = 0;
    in_deq__RDY = 1'b0;
    up_base.push_back(32'hE000_0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("nordy_deq_ena", {63'd0, in_deq__ENA}, 64'd0);
      chk("nordy_busy", {63'd0, busy}, 64'd0);
    end
    @(posedge CLK); #1;
    in_deq__RDY = 1'b1;
    @(negedge CLK);
    chk("nordy_load", {63'd0, in_deq__ENA}, 64'd1);
    wait_drain(100);
    chk("nordy_beats", 64'(beats), 64'd22);

    // Reset after beat 7 of an element
    @(posedge CLK); #1;
    beats = 0;
    up_base.push_back(32'hA000_0000);
    wait_beats(8, 100);
    out_enq__RDY = 1'b0;
    RST = 1'b1;
    exp_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    out_enq__RDY = 1'b1;
    @(negedge CLK);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_enq_ena", {63'd0, out_enq__ENA}, 64'd0);
    chk("mid_rst_deq_ena", {63'd0, in_deq__ENA}, 64'd0);
    @(posedge CLK); #1;
    beats = 0;
    up_base.push_back(32'hB000_0000);
    wait_drain(100);
    chk("post_rst_beats", 64'(beats), 64'd22);

    // Stall on the last beat with the next element waiting upstream
    @(posedge CLK); #1;
    beats = 0; deq_cnt = 0;
    up_base.push_back(32'h9000_0000);
    up_base.push_back(32'h9100_0000);
    wait_beats(21, 100);
    out_enq__RDY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("last_stall_deq_ena", {63'd0, in_deq__ENA}, 64'd0);
      chk("last_stall_last", {63'd0, out_enq_last}, 64'd1);
    end
    @(posedge CLK); #1;
    out_enq__RDY = 1'b1;
    @(negedge CLK);
    chk("last_release_deq_ena", {63'd0, in_deq__ENA}, 64'd1);
    chk("last_release_enq_ena", {63'd0, out_enq__ENA}, 64'd1);
    wait_drain(100);
    chk("last_stall_beats", 64'(beats), 64'd44);
    chk("last_stall_deq_cnt", 64'(deq_cnt), 64'd2);

    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fifo_deq_serializer.md
Name: fifo_deq_serializer

Overview:
- Reader/drain side of the single-entry guarded FIFO interface (first/deq with __ENA/__RDY).
- Pulls WIDTH-bit elements from an upstream FIFO's out_first/out_deq methods and emits each element as BEATS narrow words through a downstream guarded enq method, least-significant beat first.
- Sits between a wide datapath FIFO (704-bit records) and a 32-bit link or indication channel.

Parameters:
- WIDTH, 704, upstream element width; must be an exact multiple of BEAT.
- BEAT, 32, downstream word width.
- BEATS, WIDTH/BEAT (22), beats per element; derived, not overridden.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous reset, active-high.
- in_first  input  WIDTH  upstream out_first value.
- in_first__RDY  input  1  upstream out_first__RDY (element valid).
- in_deq__RDY  input  1  upstream out_deq__RDY.
- in_deq__ENA  output  1  drives upstream out_deq__ENA.
- out_enq_v  output  BEAT  downstream enq data.
- out_enq_last  output  1  high on final beat of an element.
- out_enq__RDY  input  1  downstream enq ready.
- out_enq__ENA  output  1  downstream enq enable.
- busy  output  1  element held and beats pending.

Behaviour:
- State:
  - busy flag.
  - Shift register buf[WIDTH-1:0].
  - Beat counter idx, width clog2(BEATS), range 0..BEATS-1.
- Reset (RST=1 at posedge): busy=0, idx=0, buf=0. Consequently in_deq__ENA=0, out_enq__ENA=0, out_enq_last=0, busy output=0.
- Guarded-method rule: ENA is never asserted unless the matching RDY is high in the same cycle. Both ENAs are combinational from current state and RDYs.
- load = in_first__RDY && in_deq__RDY && (!busy || (out_enq__ENA && out_enq_last)).
- in_deq__ENA = load.
- On load: buf <= in_first, idx <= 0, busy <= 1. The element is consumed from upstream at load time (0-cycle latency on deq).
- out_enq__ENA = busy && out_enq__RDY.
- out_enq_v = buf[BEAT-1:0] (buf is shifted, not indexed).
- out_enq_last = busy && (idx == BEATS-1).
- On out_enq__ENA and not last: buf <= buf >> BEAT, idx <= idx+1.
- On out_enq__ENA and last:
  - If load in the same cycle, reload as above (back-to-back, no bubble).
  - Otherwise busy <= 0, idx <= 0.
- Latency: first beat is presented the cycle after load. Sustained throughput is 1 beat/cycle, so one element per BEATS cycles with the upstream continuously ready.
- Backpressure: out_enq__RDY=0 holds buf, idx and out_enq_v stable. No beat is dropped or duplicated.
- Empty upstream (in_first__RDY=0): no load, busy stays 0, no output activity.
- in_first__RDY=1 with in_deq__RDY=0: no load (both required).
- Outputs while idle: out_enq_v is don't-care when busy=0; the bench must not check it.
- Reset mid-element: the partially sent element is discarded. It was already dequeued upstream and is not re-read. The next element starts at beat 0 after reset deasserts.
- idx never exceeds BEATS-1; no wrap occurs other than the explicit return to 0.

Test Plan:
- Single element: in_first = {22 words, word k = 0xA000_0000+k}, out_enq__RDY=1 constant -> in_deq__ENA pulses 1 cycle; 22 consecutive beats 0xA0000000..0xA0000015; out_enq_last only on beat 21; busy drops the next cycle.
- Back-to-back: upstream holds 3 elements ready continuously, downstream always ready -> 66 beats in 66 consecutive cycles with no gaps. in_deq__ENA fires exactly in the cycle of each last beat (plus the initial load).
- Backpressure: toggle out_enq__RDY 1,0,0,1,... during an element -> out_enq__ENA never high while RDY low; data stable across stalls; all 22 beats delivered in order exactly once.
- Empty/not-ready upstream: in_first__RDY=1, in_deq__RDY=0 for 10 cycles -> in_deq__ENA=0 and busy=0 throughout. Raising in_deq__RDY -> load on that cycle.
- Reset mid-element: assert RST after beat 7 -> next cycle busy=0, no ENAs. After release with a new element 0xB… -> first beat is its word 0, no stale 0xA… data.
- Last-beat stall with upstream ready: hold out_enq__RDY=0 on beat 21 for 5 cycles -> no in_deq__ENA until the cycle beat 21 is accepted; the reload happens in that same cycle.
